// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx: buffers one stereo pair and shifts it out in I2S (Philips) format with self-generated BCLK/LRCK
module i2s_audio_tx #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] sample_left,
    input  logic signed [15:0] sample_right,
    input  logic               sample_valid,
    output logic               sample_ready,
    output logic               i2s_bclk,
    output logic               i2s_lrck,
    output logic               i2s_data,
    output logic               underrun
);
    logic [7:0]  div_q, div_d;
    logic        bclk_q, bclk_d;
    logic [4:0]  slot_q, slot_d;
    logic        lrck_q, lrck_d;
    logic        data_q, data_d;
    logic        und_q, und_d;
    logic [15:0] left_q, left_d, right_q, right_d;
    logic [15:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic        hold_full_q, hold_full_d;
    logic        tick, fall, frame_start, xfer;

    // next state: divider, bit clock, slot sequencing, frame reload and holding register
    always_comb begin
        tick        = div_q == 8'(CLK_DIV - 1);
        fall        = tick && bclk_q;
        frame_start = fall && slot_q == 5'd31;
        xfer        = sample_valid && !hold_full_q;
        div_d       = tick ? 8'd0 : div_q + 8'd1;
        bclk_d      = tick ? ~bclk_q : bclk_q;
        slot_d      = fall ? slot_q + 5'd1 : slot_q;
        left_d      = (frame_start && hold_full_q) ? hold_l_q : left_q;
        right_d     = (frame_start && hold_full_q) ? hold_r_q : right_q;
        hold_l_d    = xfer ? sample_left : hold_l_q;
        hold_r_d    = xfer ? sample_right : hold_r_q;
        hold_full_d = xfer || (hold_full_q && !frame_start);
        und_d       = frame_start && !hold_full_q;
        lrck_d      = fall ? (slot_d >= 5'd15 && slot_d <= 5'd30) : lrck_q;
        data_d      = fall ? (slot_d[4] ? right_d[~slot_d[3:0]] : left_d[~slot_d[3:0]]) : data_q;
    end

    // state registers; reset discards any held pair and any partial word
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q       <= '0;
            bclk_q      <= 1'b0;
            slot_q      <= 5'd31;
            lrck_q      <= 1'b0;
            data_q      <= 1'b0;
            und_q       <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            hold_full_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            bclk_q      <= bclk_d;
            slot_q      <= slot_d;
            lrck_q      <= lrck_d;
            data_q      <= data_d;
            und_q       <= und_d;
            left_q      <= left_d;
            right_q     <= right_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            hold_full_q <= hold_full_d;
        end
    end

    assign sample_ready = ~hold_full_q;
    assign i2s_bclk     = bclk_q;
    assign i2s_lrck     = lrck_q;
    assign i2s_data     = data_q;
    assign underrun     = und_q;
endmodule

// File: tb/tb_i2s_audio_tx.sv
// tb_i2s_audio_tx: directed plus randomized checks against a frame-level reference model
module tb_i2s_audio_tx;
    localparam int D  = 2;
    localparam int FR = 64 * D;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] sample_left = '0;
    logic [15:0] sample_right = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready, i2s_bclk, i2s_lrck, i2s_data, underrun;

    i2s_audio_tx #(.CLK_DIV(D)) dut (
        .clk(clk), .reset(reset),
        .sample_left(sample_left), .sample_right(sample_right),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck), .i2s_data(i2s_data),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int n = 0;
    int und_seen = 0;
    bit m_full = 0;
    bit m_und = 0;
    logic [15:0] m_hl = '0, m_hr = '0, m_cl = '0, m_cr = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, n);
        end
    endtask

    // slot index after edge n: 31 until the first falling toggle, then one per BCLK period
    function automatic int slot_of();
        int m;
        m = n / (2 * D);
        return (m == 0) ? 31 : (m - 1) % 32;
    endfunction

    task automatic tick();
        bit pre, fs, eb, el, ed;
        int s;
        @(posedge clk);
        if (reset) begin
            n = 0; m_full = 0; m_und = 0;
            m_hl = '0; m_hr = '0; m_cl = '0; m_cr = '0;
        end else begin
            n++;
            pre = m_full;
            m_und = 0;
            fs = (n % FR) == 2 * D;
            if (fs) begin
                if (pre) begin m_cl = m_hl; m_cr = m_hr; m_full = 0; end
                else m_und = 1;
            end
            if (sample_valid && !pre) begin m_hl = sample_left; m_hr = sample_right; m_full = 1; end
        end
        #1;
        s  = slot_of();
        eb = ((n / D) % 2) == 1;
        el = s >= 15 && s <= 30;
        ed = (n < 2 * D) ? 1'b0 : (s < 16 ? m_cl[15 - s] : m_cr[31 - s]);
        check("outs", {27'd0, i2s_bclk, i2s_lrck, i2s_data, underrun, sample_ready},
                      {27'd0, eb, el, ed, m_und, !m_full});
        if (underrun) und_seen++;
    endtask

    task automatic offer(input logic [15:0] l, input logic [15:0] r);
        bit acc;
        int w;
        acc = 0; w = 0;
        sample_valid = 1; sample_left = l; sample_right = r;
        while (!acc && w < 4 * FR) begin acc = !m_full; tick(); w++; end
        sample_valid = 0;
        check("offer_acc", 32'(acc), 1);
    endtask

    task automatic capture(output logic [15:0] l, output logic [15:0] r);
        logic [31:0] rec;
        int k, w;
        rec = '0; w = 0;
        do begin tick(); w++; end while ((n % FR) != 2 * D && w < 4 * FR);
        check("cap_sync", 32'((n % FR) == 2 * D), 1);
        rec = {rec[30:0], i2s_data};
        k = 1;
        while (k < 32) begin
            tick();
            if (n % (2 * D) == 0) begin rec = {rec[30:0], i2s_data}; k++; end
        end
        l = rec[31:16];
        r = rec[15:0];
    endtask

    initial begin
        logic [15:0] cl, cr, xl, xr;
        int w;
        repeat (3) tick();
        check("rst_outs", {27'd0, i2s_bclk, i2s_lrck, i2s_data, underrun, sample_ready}, 32'h1);
        reset = 0;
        und_seen = 0;
        repeat (4 * FR) tick();
        check("idle_und", und_seen, 4);

        offer(16'h8001, 16'h7FFE);
        capture(cl, cr);
        check("p1_left", cl, 16'h8001);
        check("p1_right", cr, 16'h7FFE);

        offer(16'h1234, 16'hABCD);
        und_seen = 0;
        offer(16'h5555, 16'hAAAA);
        offer(16'h00FF, 16'hFF00);
        capture(cl, cr);
        check("bb_left", cl, 16'h00FF);
        check("bb_right", cr, 16'hFF00);
        check("bb_und", und_seen, 0);
        capture(cl, cr);
        check("rep1_left", cl, 16'h00FF);
        check("rep1_right", cr, 16'hFF00);
        capture(cl, cr);
        check("rep2_left", cl, 16'h00FF);
        check("rep2_right", cr, 16'hFF00);
        check("rep_und", und_seen, 2);

        w = 0;
        while (!(!m_full && ((n + 1) % FR) == 2 * D) && w < 4 * FR) begin tick(); w++; end
        check("sim_sync", 32'(((n + 1) % FR) == 2 * D), 1);
        xl = 16'($urandom); xr = 16'($urandom);
        sample_valid = 1; sample_left = xl; sample_right = xr;
        tick();
        sample_valid = 0;
        check("sim_und", 32'(underrun), 1);
        check("sim_ready", 32'(sample_ready), 0);
        capture(cl, cr);
        check("sim_left", cl, xl);
        check("sim_right", cr, xr);

        offer(16'($urandom), 16'($urandom));
        offer(16'($urandom), 16'($urandom));
        w = 0;
        while (slot_of() != 20 && w < 4 * FR) begin tick(); w++; end
        check("rst_slot", slot_of(), 20);
        check("rst_held", 32'(sample_ready), 0);
        reset = 1;
        tick();
        reset = 0;
        check("rst_mid_ready", 32'(sample_ready), 1);
        check("rst_mid_outs", {28'd0, i2s_bclk, i2s_lrck, i2s_data, underrun}, 0);
        capture(cl, cr);
        check("rst_left", cl, 0);
        check("rst_right", cr, 0);

        for (int i = 0; i < 4000; i++) begin
            sample_valid = ($urandom % 40) == 0;
            sample_left  = 16'($urandom);
            sample_right = 16'($urandom);
            reset        = ($urandom % 1500) == 0;
            tick();
        end
        reset = 0;
        sample_valid = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
